button_conditioner: RTL

- Input-conditioning controller for the io_circuits path. Takes WIDTH raw asynchronous lines (buttons, switches) and passes each through a 2-flip-flop synchroniser stage.
- Debounces each line with a shared sample-rate generator and per-channel saturating counters. Emits a clean level plus one-cycle press and release pulses for the CPU MMIO and top-level logic.
- One instance sits between the board pins and all user-input consumers.

---
 rtl/button_conditioner.sv | 100 ++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions WIDTH raw asynchronous inputs: a 2-flop synchroniser per line,
// a shared sample-rate tick, per-channel saturating debounce counters, and a
// clean level with one-cycle press/release pulses derived from it.
module button_conditioner #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int SCNT_W = $clog2(SAMPLE_CNT_MAX);
    localparam int CCNT_W = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [CCNT_W-1:0] CCNT_FULL = CCNT_W'(PULSE_CNT_MAX);

    logic [WIDTH-1:0]  r_sync1;
    logic [WIDTH-1:0]  r_sync2;
    logic [WIDTH-1:0]  r_pressed_d;
    logic [SCNT_W-1:0] r_scnt;
    logic [CCNT_W-1:0] r_ccnt [WIDTH];

    logic              w_tick;
    logic [WIDTH-1:0]  w_pressed;

    // Increment that sticks at the press threshold instead of wrapping.
    function automatic logic [CCNT_W-1:0] sat_inc(input logic [CCNT_W-1:0] cnt);
        if (cnt >= CCNT_FULL) begin
            return CCNT_FULL;
        end
        return cnt + CCNT_W'(1);
    endfunction

    // Two back-to-back flops per line with nothing in between, so the second
    // flop sees a settled value even if the first went metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running sample counter shared by every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scnt <= '0;
        end else if (w_tick) begin
            r_scnt <= '0;
        end else begin
            r_scnt <= r_scnt + SCNT_W'(1);
        end
    end

    assign w_tick = (r_scnt == SCNT_LAST);

    // Debounce counters: count consecutive high samples, any low sample clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_ccnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_ccnt[i] <= r_sync2[i] ? sat_inc(r_ccnt[i]) : '0;
            end
        end
    end

    // Debounced level is a pure decode of the counters, never of the pins.
    always_comb begin
        w_pressed = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pressed[i] = (r_ccnt[i] == CCNT_FULL);
        end
    end

    // One-cycle-delayed copy of the level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pressed_d <= '0;
        end else begin
            r_pressed_d <= w_pressed;
        end
    end

    assign pressed       = w_pressed;
    assign press_pulse   = w_pressed & ~r_pressed_d;
    assign release_pulse = ~w_pressed & r_pressed_d;

endmodule
